// File: rtl/afu_pkg.sv
// Shared AFU types for the read-data path: half-line and assembled-line
// structs, the assembler FSM state encoding and the default FIFO depth.
package afu_pkg;

  localparam int RDA_FIFO_DEPTH = 4;
  localparam int HALF_W         = 512;
  localparam int LINE_W         = 1024;

  typedef struct packed {
    logic [12:0] command;
    logic [7:0]  tag;
  } CommandTagLine;

  typedef struct packed {
    logic              valid;
    logic [HALF_W-1:0] data;
  } HalfLine;

  typedef struct packed {
    HalfLine       line;
    CommandTagLine cmd;
    logic          read_data;
    logic          wed_data;
  } DataControlInterfaceOut;

  typedef struct packed {
    logic              valid;
    CommandTagLine     cmd;
    logic              read_data;
    logic              wed_data;
    logic [LINE_W-1:0] data;
  } ReadLineAssembled;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    HAVE_LO = 2'd1,
    HAVE_HI = 2'd2
  } rda_state_t;

  // Low half occupies the upper bits; sideband comes from the completing half.
  function automatic ReadLineAssembled make_line(input logic [HALF_W-1:0]    lo_data,
                                                 input logic [HALF_W-1:0]    hi_data,
                                                 input DataControlInterfaceOut src);
    make_line           = '0;
    make_line.valid     = 1'b1;
    make_line.cmd       = src.cmd;
    make_line.read_data = src.read_data;
    make_line.wed_data  = src.wed_data;
    make_line.data      = {lo_data, hi_data};
  endfunction

endpackage

// File: rtl/read_line_fifo.sv
// Circular full-line FIFO with occupancy count. A push into a full FIFO is
// still taken when a pop happens in the same cycle; o_push_accepted reports it.
module read_line_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_push_accepted
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop        = i_pop && (r_count != '0);
  assign w_do_push       = i_push && ((r_count < CNT_W'(DEPTH)) || w_do_pop);
  assign o_push_accepted = w_do_push;
  assign o_head          = r_mem[r_rd_ptr];
  assign o_count         = r_count;

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/read_data_assembler.sv
// Pairs low/high half-lines by tag into full lines and queues them for the consumer.
// Define RDA_OUT_REG_EN to add a registered output stage (line latency 2 instead of 1).
module read_data_assembler
  import afu_pkg::*;
#(
  parameter int FIFO_DEPTH = RDA_FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   enabled,
  input  DataControlInterfaceOut half_in_0,
  input  DataControlInterfaceOut half_in_1,
  output ReadLineAssembled       line_out,
  input  logic                   line_out_ready,
  output logic                   fifo_almost_full,
  output logic [1:0]             assembly_error,
  output rda_state_t             o_dbg_state
);
  localparam int LINE_BITS = $bits(ReadLineAssembled);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  rda_state_t             r_state, w_state_nxt;
  DataControlInterfaceOut r_pend, w_pend_nxt;
  logic [1:0]             r_err;
  logic                   w_lo, w_hi, w_push, w_proto_err;
  ReadLineAssembled       w_line, w_head;
  logic [LINE_BITS-1:0]   w_head_bits;
  logic [CNT_W-1:0]       w_count;
  logic                   w_push_ok, w_fifo_pop;

  assign w_lo = enabled && half_in_0.line.valid;
  assign w_hi = enabled && half_in_1.line.valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_push      = 1'b0;
    w_line      = '0;
    w_proto_err = 1'b0;
    if (w_lo && w_hi) begin
      if (r_state == EMPTY && half_in_0.cmd.tag == half_in_1.cmd.tag) begin
        w_push = 1'b1;
        w_line = make_line(half_in_0.line.data, half_in_1.line.data, half_in_1);
      end else begin
        w_proto_err = 1'b1;
      end
      w_state_nxt = EMPTY;
      w_pend_nxt  = '0;
    end else if (w_lo) begin
      if (r_state == HAVE_HI && half_in_0.cmd.tag == r_pend.cmd.tag) begin
        w_push      = 1'b1;
        w_line      = make_line(half_in_0.line.data, r_pend.line.data, half_in_0);
        w_state_nxt = EMPTY;
        w_pend_nxt  = '0;
      end else begin
        // Any pending half is superseded: mismatched tag or a repeated low half.
        w_proto_err = (r_state != EMPTY);
        w_state_nxt = HAVE_LO;
        w_pend_nxt  = half_in_0;
      end
    end else if (w_hi) begin
      if (r_state == HAVE_LO && half_in_1.cmd.tag == r_pend.cmd.tag) begin
        w_push      = 1'b1;
        w_line      = make_line(r_pend.line.data, half_in_1.line.data, half_in_1);
        w_state_nxt = EMPTY;
        w_pend_nxt  = '0;
      end else begin
        w_proto_err = (r_state != EMPTY);
        w_state_nxt = HAVE_HI;
        w_pend_nxt  = half_in_1;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= EMPTY;
      r_pend  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_err   <= {w_push && !w_push_ok, w_proto_err};
    end
  end

  read_line_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LINE_BITS)
  ) u_fifo (
    .clock           (clock),
    .rstn            (rstn),
    .i_push          (w_push),
    .i_push_data     (w_line),
    .i_pop           (w_fifo_pop),
    .o_head          (w_head_bits),
    .o_count         (w_count),
    .o_push_accepted (w_push_ok)
  );

  assign w_head = ReadLineAssembled'(w_head_bits);

`ifdef RDA_OUT_REG_EN
  ReadLineAssembled r_out;

  // Refill whenever the stage is empty or being drained, so back-to-back lines flow.
  assign w_fifo_pop = (w_count != '0) && (!r_out.valid || line_out_ready);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_out <= '0;
    end else if (w_fifo_pop) begin
      r_out <= w_head;
    end else if (line_out_ready) begin
      r_out <= '0;
    end
  end

  assign line_out = r_out;
`else
  assign w_fifo_pop = (w_count != '0) && line_out_ready;
  assign line_out   = (w_count != '0) ? w_head : '0;
`endif

  assign fifo_almost_full = (w_count >= CNT_W'(FIFO_DEPTH - 1));
  assign assembly_error   = r_err;
  assign o_dbg_state      = r_state;

endmodule
